// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU request arbiter.
//   fpu_op_e     operator encoding carried on req_op / fpu_operator
//   RM_*         rounding-mode constants carried on req_rm / fpu_rm
//   arb_state_e  arbiter FSM states
//   rr_wrap_inc  round-robin pointer increment with wrap
package fpu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_MUL  = 3'd2,
      OP_DIV  = 3'd3,
      OP_SQRT = 3'd4
   } fpu_op_e;

   localparam logic [2:0] RM_RNE = 3'd0;
   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fpu_rr_picker.sv
// fpu_rr_picker: combinational round-robin priority select.
//   req_i    request vector
//   ptr_i    highest-priority index this cycle
//   grant_o  one-hot grant (first request at or after ptr_i, wrapping)
//   idx_o    binary index of the granted request
//   any_o    at least one request present
module fpu_rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   always_comb begin
      int unsigned j;
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      j       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = (32'(ptr_i) + i) % NUM_REQ;
         if (!any_o && req_i[j]) begin
            any_o      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter sharing one FPU among NUM_REQ requesters,
// one operation outstanding at a time (IDLE -> ISSUE -> WAIT -> RESP).
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          per-port request handshake (ready is one-hot)
//   req_op/req_rm/req_a/req_b    per-port operation fields
//   fpu_in_valid/fpu_ready       issue handshake toward the FPU
//   fpu_operator/rm/a/b/tag      issued operation (tag = granted port index)
//   fpu_res_valid/result/tag_o   FPU completion
//   rsp_valid/rsp_ready          per-port response handshake (valid is one-hot)
//   rsp_data/rsp_err             response payload
//   tag_mismatch                 sticky: FPU returned a tag other than the issued one
// Optional build macro FPU_ARB_TIMEOUT_EN: WAIT watchdog of TIMEOUT_CYCLES that
// completes the request with rsp_data=0, rsp_err=1.
module fpu_arbiter
   import fpu_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TAG_WIDTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][2:0]             req_op,
   input  logic [NUM_REQ-1:0][2:0]             req_rm,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_a,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_b,
   output logic                                fpu_in_valid,
   input  logic                                fpu_ready,
   output logic [2:0]                          fpu_operator,
   output logic [2:0]                          fpu_rm,
   output logic [DATA_WIDTH-1:0]               fpu_a,
   output logic [DATA_WIDTH-1:0]               fpu_b,
   output logic [TAG_WIDTH-1:0]                fpu_tag,
   input  logic                                fpu_res_valid,
   input  logic [DATA_WIDTH-1:0]               fpu_result,
   input  logic [TAG_WIDTH-1:0]                fpu_tag_o,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   input  logic [NUM_REQ-1:0]                  rsp_ready,
   output logic [DATA_WIDTH-1:0]               rsp_data,
   output logic                                rsp_err,
   output logic                                tag_mismatch
);

   localparam int unsigned IW    = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_e            state_q;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]         grant_q;
   logic [2:0]            op_q, rm_q;
   logic [DATA_WIDTH-1:0] a_q, b_q, rsp_data_q;
   logic                  tag_mismatch_q;
   logic [TAG_WIDTH-1:0]  issued_tag;

   logic [NUM_REQ-1:0]    pick_oh;
   logic [IW-1:0]         pick_idx;
   logic                  pick_any;

   fpu_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IW)
   ) u_picker (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_oh),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   assign rr_ptr_d   = IW'(rr_wrap_inc(32'(pick_idx), NUM_REQ));
   assign issued_tag = TAG_WIDTH'(grant_q);

`ifdef FPU_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;
   logic             rsp_err_q;
   assign rsp_err = rsp_err_q;
`else
   logic [CNT_W-1:0] unused_timeout_w;
   assign unused_timeout_w = '0;
   assign rsp_err          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         grant_q        <= '0;
         op_q           <= '0;
         rm_q           <= '0;
         a_q            <= '0;
         b_q            <= '0;
         rsp_data_q     <= '0;
         tag_mismatch_q <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
         cnt_q          <= '0;
         rsp_err_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_q  <= pick_idx;
                  op_q     <= req_op[pick_idx];
                  rm_q     <= req_rm[pick_idx];
                  a_q      <= req_a[pick_idx];
                  b_q      <= req_b[pick_idx];
                  rr_ptr_q <= rr_ptr_d;
                  state_q  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (fpu_ready) begin
                  state_q <= ST_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            ST_WAIT: begin
               if (fpu_res_valid) begin
                  rsp_data_q <= fpu_result;
                  if (fpu_tag_o != issued_tag) tag_mismatch_q <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
                  rsp_err_q  <= 1'b0;
`endif
                  state_q    <= ST_RESP;
               end
`ifdef FPU_ARB_TIMEOUT_EN
               // Counter holds WAIT cycles already elapsed; the last one expires here.
               else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
                  state_q    <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready[grant_q]) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (state_q == ST_IDLE) req_ready = pick_oh;
      if (state_q == ST_RESP) rsp_valid[grant_q] = 1'b1;
   end

   assign fpu_in_valid = (state_q == ST_ISSUE);
   assign fpu_operator = op_q;
   assign fpu_rm       = rm_q;
   assign fpu_a        = a_q;
   assign fpu_b        = b_q;
   assign fpu_tag      = issued_tag;
   assign rsp_data     = rsp_data_q;
   assign tag_mismatch = tag_mismatch_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: self-checking bench for fpu_arbiter. The bench plays all
// requesters and the FPU; a round-robin pointer and sticky-mismatch flag are
// kept as a reference model. The timeout sequence runs when FPU_ARB_TIMEOUT_EN
// is defined.
module tb_fpu_arbiter;
   import fpu_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int TW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid, req_ready;
   logic [N-1:0][2:0]    req_op, req_rm;
   logic [N-1:0][DW-1:0] req_a, req_b;
   logic                 fpu_in_valid, fpu_ready;
   logic [2:0]           fpu_operator, fpu_rm;
   logic [DW-1:0]        fpu_a, fpu_b;
   logic [TW-1:0]        fpu_tag;
   logic                 fpu_res_valid;
   logic [DW-1:0]        fpu_result;
   logic [TW-1:0]        fpu_tag_o;
   logic [N-1:0]         rsp_valid, rsp_ready;
   logic [DW-1:0]        rsp_data;
   logic                 rsp_err, tag_mismatch;

   int   vectors     = 0;
   int   miscompares = 0;
   int   ptr_m       = 0;
   logic mm_m        = 1'b0;

   always #5 clk = ~clk;

   fpu_arbiter #(
      .NUM_REQ        (N),
      .DATA_WIDTH     (DW),
      .TAG_WIDTH      (TW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_rm        (req_rm),
      .req_a         (req_a),
      .req_b         (req_b),
      .fpu_in_valid  (fpu_in_valid),
      .fpu_ready     (fpu_ready),
      .fpu_operator  (fpu_operator),
      .fpu_rm        (fpu_rm),
      .fpu_a         (fpu_a),
      .fpu_b         (fpu_b),
      .fpu_tag       (fpu_tag),
      .fpu_res_valid (fpu_res_valid),
      .fpu_result    (fpu_result),
      .fpu_tag_o     (fpu_tag_o),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .tag_mismatch  (tag_mismatch)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference arbitration: first valid port at or after the pointer, wrapping.
   function automatic int model_pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++)
         if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic randomize_ports();
      for (int p = 0; p < N; p++) begin
         req_op[p] = 3'($urandom_range(0, 4));
         req_rm[p] = 3'($urandom_range(0, 4));
         req_a[p]  = $urandom;
         req_b[p]  = $urandom;
      end
   endtask

   // Handshake at the current IDLE cycle and one ISSUE cycle with fpu_ready=1;
   // returns 1 ns after the edge that entered WAIT.
   task automatic start_to_wait(input string nm, input logic [N-1:0] mask, input int g);
      logic [N-1:0] oh;
      oh = 4'(1) << g;
      randomize_ports();
      req_valid = mask;
      #1;
      chk({nm, ".req_ready"}, 64'(req_ready), 64'(oh));
      ptr_m = (g + 1) % N;
      cyc();
      req_valid = '0;
      fpu_ready = 1'b1;
      #1;
      chk({nm, ".in_valid"}, 64'(fpu_in_valid), 64'd1);
      cyc();
      fpu_ready = 1'b0;
   endtask

   task automatic do_txn(input string nm, input logic [N-1:0] mask, input int rstall,
                         input int lat, input bit tag_err, input int pstall,
                         input bit fixed, input int g);
      logic [N-1:0]  oh;
      logic [2:0]    e_op, e_rm;
      logic [DW-1:0] e_a, e_b, e_res;
      oh = 4'(1) << g;
      randomize_ports();
      if (fixed) begin
         req_op[g] = OP_ADD;
         req_rm[g] = RM_RNE;
         req_a[g]  = 32'h3F80_0000;
         req_b[g]  = 32'h4000_0000;
      end
      req_valid = mask;
      e_op  = req_op[g];
      e_rm  = req_rm[g];
      e_a   = req_a[g];
      e_b   = req_b[g];
      e_res = fixed ? 32'h4040_0000 : e_a + e_b;
      #1;
      chk({nm, ".req_ready"}, 64'(req_ready), 64'(oh));
      chk({nm, ".idle_in_valid"}, 64'(fpu_in_valid), 64'd0);
      chk({nm, ".idle_rsp_valid"}, 64'(rsp_valid), 64'd0);
      ptr_m = (g + 1) % N;
      cyc();
      // ISSUE: request inputs churn and stray results arrive; both must be ignored.
      for (int i = 0; i <= rstall; i++) begin
         randomize_ports();
         req_valid     = 4'($urandom);
         fpu_ready     = (i == rstall);
         fpu_res_valid = (i != rstall) && ($urandom_range(0, 1) == 1);
         fpu_result    = $urandom;
         fpu_tag_o     = TW'(g);
         #1;
         chk({nm, ".in_valid"}, 64'(fpu_in_valid), 64'd1);
         chk({nm, ".op"}, 64'(fpu_operator), 64'(e_op));
         chk({nm, ".rm"}, 64'(fpu_rm), 64'(e_rm));
         chk({nm, ".a"}, 64'(fpu_a), 64'(e_a));
         chk({nm, ".b"}, 64'(fpu_b), 64'(e_b));
         chk({nm, ".tag"}, 64'(fpu_tag), 64'(g));
         chk({nm, ".issue_req_ready"}, 64'(req_ready), 64'd0);
         cyc();
      end
      fpu_ready     = 1'b0;
      fpu_res_valid = 1'b0;
      for (int i = 0; i < lat; i++) begin
         #1;
         chk({nm, ".wait_in_valid"}, 64'(fpu_in_valid), 64'd0);
         chk({nm, ".wait_rsp_valid"}, 64'(rsp_valid), 64'd0);
         cyc();
      end
      fpu_res_valid = 1'b1;
      fpu_result    = e_res;
      fpu_tag_o     = tag_err ? TW'(g + 1) : TW'(g);
      #1;
      chk({nm, ".wait_in_valid"}, 64'(fpu_in_valid), 64'd0);
      chk({nm, ".wait_rsp_valid"}, 64'(rsp_valid), 64'd0);
      cyc();
      if (tag_err) mm_m = 1'b1;
      // RESP: non-granted rsp_ready and stray results must not complete or disturb it.
      for (int i = 0; i <= pstall; i++) begin
         rsp_ready     = (i == pstall) ? oh : ~oh;
         fpu_res_valid = (i < pstall);
         fpu_result    = $urandom;
         #1;
         chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'(oh));
         chk({nm, ".rsp_data"}, 64'(rsp_data), 64'(e_res));
         chk({nm, ".rsp_err"}, 64'(rsp_err), 64'd0);
         chk({nm, ".resp_req_ready"}, 64'(req_ready), 64'd0);
         chk({nm, ".resp_in_valid"}, 64'(fpu_in_valid), 64'd0);
         cyc();
      end
      rsp_ready     = '0;
      req_valid     = '0;
      fpu_res_valid = 1'b0;
      #1;
      chk({nm, ".done_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({nm, ".tag_mismatch"}, 64'(tag_mismatch), 64'(mm_m));
   endtask

   typedef struct {
      logic [N-1:0] mask;
      int           rstall;
      int           lat;
      bit           tag_err;
      int           pstall;
      bit           fixed;
      int           exp_g;
      string        nm;
   } vec_t;

   vec_t tbl[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int g;
      tbl[0] = '{4'b1111, 0, 0, 1'b0, 0, 1'b0, 0, "all4_a"};
      tbl[1] = '{4'b1111, 0, 1, 1'b0, 0, 1'b0, 1, "all4_b"};
      tbl[2] = '{4'b1111, 1, 0, 1'b0, 0, 1'b0, 2, "all4_c"};
      tbl[3] = '{4'b1111, 0, 2, 1'b0, 1, 1'b0, 3, "all4_d"};
      tbl[4] = '{4'b0100, 0, 1, 1'b0, 0, 1'b1, 2, "add_p2"};
      tbl[5] = '{4'b0011, 5, 0, 1'b0, 0, 1'b0, 0, "stall5"};
      tbl[6] = '{4'b1001, 0, 0, 1'b0, 3, 1'b0, 3, "rsp_hold3"};
      tbl[7] = '{4'b0001, 0, 1, 1'b1, 0, 1'b0, 0, "tag_bad"};
      tbl[8] = '{4'b0001, 0, 0, 1'b0, 0, 1'b0, 0, "tag_sticky"};
      tbl[9] = '{4'b0110, 0, 3, 1'b0, 0, 1'b0, 1, "wrap_p1"};

      rst           = 1'b1;
      req_valid     = '0;
      rsp_ready     = '0;
      fpu_ready     = 1'b0;
      fpu_res_valid = 1'b0;
      fpu_result    = '0;
      fpu_tag_o     = '0;
      randomize_ports();
      cyc();
      cyc();
      chk("reset.req_ready", 64'(req_ready), 64'd0);
      chk("reset.in_valid", 64'(fpu_in_valid), 64'd0);
      chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset.rsp_data", 64'(rsp_data), 64'd0);
      chk("reset.rsp_err", 64'(rsp_err), 64'd0);
      chk("reset.tag_mismatch", 64'(tag_mismatch), 64'd0);
      chk("reset.fpu_a", 64'(fpu_a), 64'd0);
      chk("reset.fpu_tag", 64'(fpu_tag), 64'd0);
      rst = 1'b0;
      cyc();

      foreach (tbl[i])
         do_txn(tbl[i].nm, tbl[i].mask, tbl[i].rstall, tbl[i].lat, tbl[i].tag_err,
                tbl[i].pstall, tbl[i].fixed, tbl[i].exp_g);

`ifdef FPU_ARB_TIMEOUT_EN
      begin
         logic [N-1:0] oh;
         g  = model_pick(4'b0010, ptr_m);
         oh = 4'(1) << g;
         start_to_wait("timeout", 4'b0010, g);
         for (int i = 0; i < 8; i++) begin
            #1;
            chk("timeout.wait_rsp_valid", 64'(rsp_valid), 64'd0);
            cyc();
         end
         #1;
         chk("timeout.rsp_valid", 64'(rsp_valid), 64'(oh));
         chk("timeout.rsp_data", 64'(rsp_data), 64'd0);
         chk("timeout.rsp_err", 64'(rsp_err), 64'd1);
         rsp_ready = oh;
         cyc();
         rsp_ready = '0;
         #1;
         chk("timeout.done_rsp_valid", 64'(rsp_valid), 64'd0);
      end
`endif

      // Reset while WAITing: request is dropped, pointer and sticky flag clear.
      g = model_pick(4'b0100, ptr_m);
      start_to_wait("rst_wait", 4'b0100, g);
      cyc();
      rst = 1'b1;
      #1;
      chk("rst_wait.rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_wait.in_valid", 64'(fpu_in_valid), 64'd0);
      chk("rst_wait.tag_mismatch", 64'(tag_mismatch), 64'd0);
      chk("rst_wait.rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_wait.fpu_tag", 64'(fpu_tag), 64'd0);
      cyc();
      rst   = 1'b0;
      ptr_m = 0;
      mm_m  = 1'b0;
      fpu_res_valid = 1'b1;
      fpu_result    = 32'hDEAD_BEEF;
      fpu_tag_o     = TW'(g);
      #1;
      chk("rst_wait.stale_rsp_valid", 64'(rsp_valid), 64'd0);
      cyc();
      fpu_res_valid = 1'b0;
      #1;
      chk("rst_wait.idle_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_wait.idle_in_valid", 64'(fpu_in_valid), 64'd0);
      cyc();
      do_txn("post_rst", 4'b1111, 0, 0, 1'b0, 0, 1'b0, 0);

      for (int t = 0; t < 40; t++) begin
         logic [N-1:0] m;
         if ($urandom_range(0, 4) == 0) begin
            req_valid = '0;
            #1;
            chk("rand.idle_req_ready", 64'(req_ready), 64'd0);
            cyc();
         end else begin
            m = 4'($urandom_range(1, 15));
            g = model_pick(m, ptr_m);
            do_txn("rand", m, $urandom_range(0, 3), $urandom_range(0, 4),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'b0, g);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-003 Parameter TAG_WIDTH, default 4, FPU tag width; SHALL be >= clog2(NUM_REQ).
REQ-004 Parameter TIMEOUT_CYCLES, default 64, watchdog limit (used only with FPU_ARB_TIMEOUT_EN).
REQ-005 clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-008 req_op  input  NUM_REQ x 3  operator per requester (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SQRT).
REQ-009 req_rm  input  NUM_REQ x 3  rounding mode per requester.
REQ-010 req_a / req_b  input  NUM_REQ x DATA_WIDTH  operands.
REQ-011 fpu_in_valid  output  1; fpu_ready  input  1  controller idle/accept.
REQ-012 fpu_operator, fpu_rm  output  3 each; fpu_a, fpu_b  output  DATA_WIDTH; fpu_tag  output  TAG_WIDTH.
REQ-013 fpu_res_valid  input  1; fpu_result  input  DATA_WIDTH; fpu_tag_o  input  TAG_WIDTH.
REQ-014 rsp_valid  output  NUM_REQ  one-hot; rsp_ready  input  NUM_REQ.
REQ-015 rsp_data  output  DATA_WIDTH; rsp_err  output  1; tag_mismatch  output  1 (sticky).

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one operation outstanding at a time.
REQ-017 IDLE: if any req_valid, grant lowest index at or after rr_ptr (round-robin, wrapping NUM_REQ-1 -> 0); assert req_ready[grant] for exactly that cycle; latch op, rm, a, b, grant index; go to ISSUE.
REQ-018 rr_ptr SHALL update to (grant+1) mod NUM_REQ on each grant; unchanged otherwise.
REQ-019 ISSUE: drive fpu_in_valid=1 with latched fields, fpu_tag = zero-extended grant index; when fpu_ready=1 go to WAIT, else hold all fpu_* outputs stable.
REQ-020 fpu_in_valid SHALL be 0 in every state other than ISSUE.
REQ-021 WAIT: on fpu_res_valid latch fpu_result into rsp_data, go to RESP; if fpu_tag_o != issued tag, set tag_mismatch and still complete.
REQ-022 RESP: rsp_valid[grant]=1, rsp_data/rsp_err stable until rsp_ready[grant]=1, then IDLE same edge.
REQ-023 Minimum latency req handshake -> rsp_valid: 2 cycles plus FPU latency; no new grant before return to IDLE.
REQ-024 Simultaneous fpu_res_valid in non-WAIT states SHALL be ignored.
REQ-025 rsp_ready on non-granted ports and req_valid changes during ISSUE/WAIT/RESP SHALL be ignored.

Reset
REQ-026 On rst: state IDLE, rr_ptr 0, all latched fields 0, req_ready 0, fpu_in_valid 0, rsp_valid 0, rsp_data 0, rsp_err 0, tag_mismatch 0.
REQ-027 rst mid-operation SHALL abort immediately; no rsp_valid is produced for the aborted request.

Configuration
REQ-028 Macro FPU_ARB_TIMEOUT_EN defined: counter in WAIT increments each cycle; at TIMEOUT_CYCLES without fpu_res_valid go to RESP with rsp_data=0, rsp_err=1; counter clears on entering WAIT.
REQ-029 Macro undefined: no counter; WAIT persists until fpu_res_valid; rsp_err tied 0.

Structure
REQ-030 Package fpu_pkg SHALL hold operator enum (ADD..SQRT), rounding-mode constants, and the arbiter state typedef.
REQ-031 Sub-module fpu_rr_picker (combinational round-robin priority select: req vector + pointer -> one-hot grant + index) SHALL be instantiated once.

Verification
REQ-032 All 4 ports valid simultaneously after reset -> grants in order 0,1,2,3, each with one rsp_valid on matching port.
REQ-033 Port 2 ADD 0x3F800000 + 0x40000000, fpu returns 0x40400000 with tag 2 -> rsp_valid[2], rsp_data 0x40400000, rsp_err 0.
REQ-034 fpu_ready held 0 for 5 cycles in ISSUE -> fpu_in_valid and fields stable all 5 cycles, single transfer.
REQ-035 rsp_ready low 3 cycles -> rsp_valid/rsp_data held, no new grant; FPU returns tag 1 for issued tag 0 -> tag_mismatch=1 sticky.
REQ-036 FPU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no fpu_res_valid -> rsp_err=1, rsp_data 0 after 8 WAIT cycles; rst asserted in WAIT -> no response, rr_ptr 0.
